spi_dac_arbiter: RTL
====================

SPI_DAC_ARBITER -- requirements
Module: spi_dac_arbiter

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be synchronous and active-high, with ports named clk_i and rst_i.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 req_i  input  4  per-channel write request, bit n = channel n; held high until the matching ack_o pulse.
REQ-005 data_i  input  64  per-channel 16-bit DAC word; channel n occupies bits [16n+15:16n].
REQ-006 eow_i  input  1  end-of-write pulse from the shared SPI writer.
REQ-007 strw_o  output  1  one-cycle start-write pulse to the SPI writer.
REQ-008 data_o  output  16  registered word presented to the SPI writer.
REQ-009 gnt_o  output  2  index of the granted channel.
REQ-010 ack_o  output  4  one-cycle completion pulse, one-hot on the served channel.
REQ-011 busy_o  output  1  high whenever the state is not IDLE.
REQ-012 err_o  output  1  sticky timeout flag; tied 0 when the timeout feature is absent.

Function
REQ-013 The state machine SHALL have four states: IDLE, STRT, WAIT and DONE.
REQ-014 IDLE behaviour:
- The block SHALL sample req_i.
- If any bit is set, it SHALL select a channel round-robin, searching upward from last_gnt+1 modulo 4.
- It SHALL register gnt_o and data_o from the selected data_i slice, then go to STRT.
- Otherwise it SHALL stay in IDLE.
REQ-015 STRT SHALL assert strw_o for exactly one cycle, ignore eow_i, and go to WAIT unconditionally.
REQ-016 WAIT SHALL remain until eow_i=1 is sampled, then go to DONE.
REQ-017 DONE SHALL:
- assert ack_o[gnt_o] for exactly one cycle;
- load last_gnt with gnt_o;
- return to IDLE.
REQ-018 Latency: req_i sampled high in IDLE at edge N → strw_o high during cycle N+1 → eow_i sampled at edge M → ack_o high during cycle M+1.
REQ-019 Minimum turnaround is 4 cycles per transaction; the next grant decision SHALL be made in the IDLE cycle after DONE.
REQ-020 data_o and gnt_o SHALL hold stable from grant until the next grant; changes on data_i after the grant SHALL be ignored.
REQ-021 A requester dropping req_i after its grant SHALL NOT abort the transaction; ack_o SHALL still pulse.
REQ-022 With all four req_i bits high continuously, grants SHALL rotate 0,1,2,3,0,…, so no channel waits more than 3 transactions.
REQ-023 strw_o and ack_o SHALL be decoded from the state only, never from inputs; at most one ack_o bit SHALL be high in any cycle.
REQ-024 eow_i arriving in IDLE, STRT or DONE SHALL be ignored.
REQ-025 Illegal or unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 rst_i high at a rising edge SHALL force, on the next cycle:
- state IDLE;
- strw_o=0, ack_o=0, busy_o=0, gnt_o=0, data_o=0, err_o=0;
- last_gnt=3, so channel 0 is served first.
REQ-027 Reset during STRT, WAIT or DONE SHALL abandon the transaction with no ack_o pulse.
REQ-028 req_i still high after reset release SHALL be arbitrated afresh.

Configuration
REQ-029 The macro SPI_DAC_ARBITER_TIMEOUT_EN SHALL control the timeout feature.
REQ-030 When SPI_DAC_ARBITER_TIMEOUT_EN is defined:
- a 10-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if the counter reaches 1023 with no eow_i, the block SHALL go to DONE, ack the channel normally, and set err_o;
- err_o SHALL stay high until reset.
REQ-031 When SPI_DAC_ARBITER_TIMEOUT_EN is undefined:
- WAIT SHALL wait indefinitely for eow_i;
- no counter SHALL be synthesized;
- err_o SHALL be constant 0.

Verification
REQ-032 Single request: req_i=4'b0100, data_i[47:32]=16'hA5C3, eow_i pulsed 10 cycles after strw_o → gnt_o=2, data_o=16'hA5C3, one strw_o pulse, ack_o=4'b0100 for one cycle, busy_o low afterwards.
REQ-033 All requests held: req_i=4'b1111 for 8 transactions → grant order 0,1,2,3,0,1,2,3; exactly 8 strw_o and 8 ack_o pulses.
REQ-034 Data change after grant: data_i[15:0] changed from 16'h0001 to 16'hFFFF during WAIT → data_o stays 16'h0001 until the next grant.
REQ-035 Reset in WAIT: rst_i pulsed 3 cycles after strw_o → all outputs 0 next cycle, no ack_o pulse; held req_i=4'b0001 regranted with gnt_o=0.
REQ-036 Spurious eow: eow_i high in IDLE and STRT → no state change and no ack_o pulse; only an eow_i in WAIT completes.
REQ-037 Timeout (macro defined): eow_i held low → ack_o pulses after 1023 WAIT cycles, err_o=1 and stays high; macro undefined → busy_o stays 1 and err_o stays 0 for 2000 cycles.

Source files
------------

// File: rtl/spi_dac_arbiter.sv
// spi_dac_arbiter: round-robin arbiter sharing one SPI DAC writer among four channels.
// Define SPI_DAC_ARBITER_TIMEOUT_EN to bound the WAIT state and raise a sticky err_o.
module spi_dac_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [63:0] data_i,
    input  logic        eow_i,
    output logic        strw_o,
    output logic [15:0] data_o,
    output logic [1:0]  gnt_o,
    output logic [3:0]  ack_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRT = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last_gnt;
    logic [1:0] pick;
    logic       pick_vld;
    logic       tmo;

    // Lowest offset from last_gnt+1 wins; offset 4 wraps onto last_gnt itself.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req_i[last_gnt + 2'(k)]) begin
                pick     = last_gnt + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

`ifdef SPI_DAC_ARBITER_TIMEOUT_EN
    logic [9:0] wcnt;
    logic       err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt  <= 10'd0;
            err_q <= 1'b0;
        end else begin
            if (state == STRT) begin
                wcnt <= 10'd0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + 10'd1;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    // Counter reaches 1023 on the edge that leaves WAIT.
    assign tmo   = (state == WAIT) && !eow_i && (wcnt == 10'd1022);
    assign err_o = err_q;
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = pick_vld ? STRT : IDLE;
            STRT:    state_nxt = WAIT;
            WAIT:    state_nxt = (eow_i || tmo) ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_o    <= 2'd0;
            data_o   <= 16'd0;
            last_gnt <= 2'd3;
        end else begin
            if (state == IDLE && pick_vld) begin
                gnt_o  <= pick;
                data_o <= data_i[{pick, 4'b0000} +: 16];
            end
            if (state == DONE) begin
                last_gnt <= gnt_o;
            end
        end
    end

    assign strw_o = (state == STRT);
    assign busy_o = (state != IDLE);
    assign ack_o  = (state == DONE) ? (4'b0001 << gnt_o) : 4'b0000;

endmodule
